// File: rtl/rx_frame_parser.sv
// rx_frame_parser: parses framed commands from a byte-wide UART receive core.
//
// Frame on the wire: 0x55 0xAA CMD LEN payload[LEN] CHK,
// where CHK = (CMD + LEN + sum of payload bytes) mod 256.
//
// Parameters
//   TIMEOUT_CYCLES  inter-byte timeout in clk cycles
//   MAX_LEN         largest accepted payload length (at most 8)
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   Rx_Data      received byte, sampled in the cycle Rx_Done_Sig is low
//   Rx_Done_Sig  active-low one-clk byte-done strobe
//   Rx_En_Sig    receive-core enable, high in every clk after reset release
//   Frm_Cmd      command byte of the last good frame
//   Frm_Len      payload length of the last good frame
//   Frm_Payload  payload of the last good frame, byte k at [8k+7:8k], unused bytes zero
//   Frm_Valid    one-clk pulse when a good frame completes
//   Frm_Err      one-clk pulse when a frame is aborted
//   Err_Code     abort cause with Frm_Err: 1 checksum, 2 length, 3 timeout
module rx_frame_parser #(
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd500000,
  parameter logic [3:0]  MAX_LEN        = 4'd8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  Rx_Data,
  input  logic        Rx_Done_Sig,
  output logic        Rx_En_Sig,
  output logic [7:0]  Frm_Cmd,
  output logic [3:0]  Frm_Len,
  output logic [63:0] Frm_Payload,
  output logic        Frm_Valid,
  output logic        Frm_Err,
  output logic [1:0]  Err_Code
);

  typedef enum logic [2:0] {
    StIdle,
    StHdr2,
    StCmd,
    StLen,
    StPay,
    StChk
  } state_e;

  localparam logic [1:0] ErrChecksum = 2'd1;
  localparam logic [1:0] ErrLength   = 2'd2;
  localparam logic [1:0] ErrTimeout  = 2'd3;

  state_e      state_q;
  logic [7:0]  cmd_q;
  logic [3:0]  len_q;
  logic [2:0]  idx_q;
  logic [7:0]  sum_q;
  logic [63:0] buf_q;
  logic [19:0] tmo_cnt_q;

  logic byte_evt;
  assign byte_evt = ~Rx_Done_Sig;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cmd_q       <= 8'h00;
      len_q       <= 4'd0;
      idx_q       <= 3'd0;
      sum_q       <= 8'h00;
      buf_q       <= 64'h0;
      tmo_cnt_q   <= 20'd0;
      Rx_En_Sig   <= 1'b0;
      Frm_Cmd     <= 8'h00;
      Frm_Len     <= 4'd0;
      Frm_Payload <= 64'h0;
      Frm_Valid   <= 1'b0;
      Frm_Err     <= 1'b0;
      Err_Code    <= 2'd0;
    end else begin
      Rx_En_Sig <= 1'b1;
      Frm_Valid <= 1'b0;
      Frm_Err   <= 1'b0;

      if (byte_evt) begin
        // A byte event always restarts the timeout, even on the cycle it would expire.
        tmo_cnt_q <= 20'd0;
        unique case (state_q)
          StIdle: begin
            if (Rx_Data == 8'h55) state_q <= StHdr2;
          end
          StHdr2: begin
            if (Rx_Data == 8'hAA) begin
              state_q <= StCmd;
            end else if (Rx_Data != 8'h55) begin
              state_q <= StIdle;
            end
          end
          StCmd: begin
            cmd_q   <= Rx_Data;
            sum_q   <= Rx_Data;
            state_q <= StLen;
          end
          StLen: begin
            if (Rx_Data > {4'd0, MAX_LEN}) begin
              state_q  <= StIdle;
              Frm_Err  <= 1'b1;
              Err_Code <= ErrLength;
            end else begin
              len_q   <= Rx_Data[3:0];
              sum_q   <= sum_q + Rx_Data;
              idx_q   <= 3'd0;
              buf_q   <= 64'h0;
              state_q <= (Rx_Data == 8'h00) ? StChk : StPay;
            end
          end
          StPay: begin
            buf_q[{idx_q, 3'b000} +: 8] <= Rx_Data;
            sum_q <= sum_q + Rx_Data;
            idx_q <= idx_q + 3'd1;
            if ({1'b0, idx_q} == len_q - 4'd1) state_q <= StChk;
          end
          StChk: begin
            state_q <= StIdle;
            if (Rx_Data == sum_q) begin
              Frm_Cmd     <= cmd_q;
              Frm_Len     <= len_q;
              Frm_Payload <= buf_q;
              Frm_Valid   <= 1'b1;
            end else begin
              Frm_Err  <= 1'b1;
              Err_Code <= ErrChecksum;
            end
          end
          default: state_q <= StIdle;
        endcase
      end else if (state_q == StIdle) begin
        tmo_cnt_q <= 20'd0;
      end else if (tmo_cnt_q == TIMEOUT_CYCLES - 20'd1) begin
        tmo_cnt_q <= 20'd0;
        state_q   <= StIdle;
        Frm_Err   <= 1'b1;
        Err_Code  <= ErrTimeout;
      end else begin
        tmo_cnt_q <= tmo_cnt_q + 20'd1;
      end
    end
  end

endmodule
